// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared encodings, MDU defaults and the per-source stall/forward decisions.
package hazard_ctrl_pkg;
    typedef enum logic [1:0] {WA_RT = 2'b00, WA_RD = 2'b01, WA_RA = 2'b10, WA_NONE = 2'b11} wa_sel_e;
    localparam logic [1:0] TUSE_D = 2'd0, TUSE_E = 2'd1, TUSE_M = 2'd2, TUSE_NONE = 2'd3;
    localparam logic [1:0] TNEW_JAL = 2'd0, TNEW_ALU = 2'd1, TNEW_LOAD = 2'd2;
    localparam logic [1:0] FWD_NONE = 2'b00, FWD_E = 2'b01, FWD_M = 2'b10, FWD_W = 2'b11;
    localparam int MDU_MULT_CYC_DEF = 5;
    localparam int MDU_DIV_CYC_DEF = 10;
    typedef struct packed {
        logic [4:0] wa;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       md_start;
        logic       md_div;
    } e_stage_t;
    function automatic logic [4:0] dec_wa(input logic [1:0] sel, input logic [4:0] rt, input logic [4:0] rd);
        return sel == WA_RT ? rt : sel == WA_RD ? rd : sel == WA_RA ? 5'd31 : 5'd0;
    endfunction
    // $0 is never a real producer, so it can neither stall nor forward
    function automatic logic hit(input logic [4:0] src, input logic [4:0] wa);
        return src != 5'd0 && src == wa;
    endfunction
    function automatic logic must_stall(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] wa, input logic [1:0] tnew);
        return tuse != TUSE_NONE && hit(src, wa) && tnew > tuse;
    endfunction
    function automatic logic [1:0] fwd_d(input logic [4:0] src, input logic [4:0] e_wa, input logic [1:0] e_tnew,
                                         input logic [4:0] m_wa, input logic [1:0] m_tnew);
        return hit(src, e_wa) && e_tnew == 2'd0 ? FWD_E : hit(src, m_wa) && m_tnew == 2'd0 ? FWD_M : FWD_NONE;
    endfunction
    function automatic logic [1:0] fwd_e(input logic [4:0] src, input logic [4:0] m_wa, input logic [1:0] m_tnew,
                                         input logic [4:0] w_wa);
        return hit(src, m_wa) && m_tnew == 2'd0 ? FWD_M : hit(src, w_wa) ? FWD_W : FWD_NONE;
    endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: D-stage decode fields toward the hazard unit, stall/forward/tracking back.
interface hazard_ctrl_if;
    logic [1:0] d_sel_grf_wa;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [4:0] d_rd;
    logic [1:0] d_tuse_rs;
    logic [1:0] d_tuse_rt;
    logic [1:0] d_tnew;
    logic       d_md_start;
    logic       d_md_div;
    logic       d_md_use;
    logic       stall;
    logic [4:0] e_wa;
    logic [4:0] m_wa;
    logic [4:0] w_wa;
    logic [1:0] fwd_d_rs;
    logic [1:0] fwd_d_rt;
    logic [1:0] fwd_e_rs;
    logic [1:0] fwd_e_rt;
    logic       md_busy;
    modport master (
        output d_sel_grf_wa, d_rs, d_rt, d_rd, d_tuse_rs, d_tuse_rt, d_tnew, d_md_start, d_md_div, d_md_use,
        input  stall, e_wa, m_wa, w_wa, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy
    );
    modport slave (
        input  d_sel_grf_wa, d_rs, d_rt, d_rd, d_tuse_rs, d_tuse_rt, d_tnew, d_md_start, d_md_div, d_md_use,
        output stall, e_wa, m_wa, w_wa, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy
    );
endinterface

// File: rtl/hazard_mdu_cnt.sv
// hazard_mdu_cnt: HI/LO occupancy counter, loaded as a mult/div leaves E and counted down to idle.
module hazard_mdu_cnt #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy
);
    localparam int CW = $clog2((MULT_CYC > DIV_CYC ? MULT_CYC : DIV_CYC) + 1);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYC);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYC);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else cnt <= start ? (div ? DIV_LD : MULT_LD) : cnt - CW'(cnt != '0);
    assign busy = cnt != '0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forward control for a 5-stage MIPS pipeline using Tuse/Tnew tracking,
// plus HI/LO interlock against an in-flight mult/div.
import hazard_ctrl_pkg::*;
module hazard_ctrl #(
    parameter int MDU_MULT_CYC = MDU_MULT_CYC_DEF,
    parameter int MDU_DIV_CYC  = MDU_DIV_CYC_DEF
) (
    input logic clk,
    input logic reset,
    hazard_ctrl_if.slave hz
);
    e_stage_t   e_q;
    logic [4:0] m_wa_q, w_wa_q, d_wa;
    logic [1:0] m_tnew_q;
    logic       data_stall, mdu_stall, stall, md_busy;
    always_comb begin
        d_wa = dec_wa(hz.d_sel_grf_wa, hz.d_rt, hz.d_rd);
        data_stall = must_stall(hz.d_rs, hz.d_tuse_rs, e_q.wa, e_q.tnew)
                   | must_stall(hz.d_rt, hz.d_tuse_rt, e_q.wa, e_q.tnew)
                   | must_stall(hz.d_rs, hz.d_tuse_rs, m_wa_q, m_tnew_q)
                   | must_stall(hz.d_rt, hz.d_tuse_rt, m_wa_q, m_tnew_q);
        mdu_stall = hz.d_md_use & (md_busy | e_q.md_start);
        stall = data_stall | mdu_stall;
    end
    // a stalled D leaves a bubble in E, so a held mult/div never reaches the counter early
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            e_q      <= '0;
            m_wa_q   <= '0;
            m_tnew_q <= '0;
            w_wa_q   <= '0;
        end else begin
            e_q      <= stall ? '0 : {d_wa, hz.d_tnew, hz.d_rs, hz.d_rt, hz.d_md_start, hz.d_md_div};
            m_wa_q   <= e_q.wa;
            m_tnew_q <= e_q.tnew - 2'(e_q.tnew != 2'd0);
            w_wa_q   <= m_wa_q;
        end
    hazard_mdu_cnt #(.MULT_CYC(MDU_MULT_CYC), .DIV_CYC(MDU_DIV_CYC)) u_mdu (
        .clk   (clk),
        .reset (reset),
        .start (e_q.md_start),
        .div   (e_q.md_div),
        .busy  (md_busy)
    );
    assign hz.stall    = stall;
    assign hz.md_busy  = md_busy;
    assign hz.e_wa     = e_q.wa;
    assign hz.m_wa     = m_wa_q;
    assign hz.w_wa     = w_wa_q;
    assign hz.fwd_d_rs = fwd_d(hz.d_rs, e_q.wa, e_q.tnew, m_wa_q, m_tnew_q);
    assign hz.fwd_d_rt = fwd_d(hz.d_rt, e_q.wa, e_q.tnew, m_wa_q, m_tnew_q);
    assign hz.fwd_e_rs = fwd_e(e_q.rs, m_wa_q, m_tnew_q, w_wa_q);
    assign hz.fwd_e_rt = fwd_e(e_q.rt, m_wa_q, m_tnew_q, w_wa_q);
endmodule
